// File: rtl/nmr_acq_pkg.sv
// Shared types and constants for the NMR echo acquisition path.
// Optional build macro: NMR_ECHO_TAG_EN widens each gated sample with the
// 16-bit echo index it belongs to.
package nmr_acq_pkg;

  localparam int ADC_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int ECHO_TAG_W    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    CAPTURE  = 2'd2,
    FINISH   = 2'd3
  } state_e;

  // Width of one word handed to the acquisition FIFO.
  function automatic int out_width(input int adc_w);
`ifdef NMR_ECHO_TAG_EN
    return adc_w + ECHO_TAG_W;
`else
    return adc_w;
`endif
  endfunction

endpackage

// File: rtl/nmr_out_stage.sv
// Single-entry valid/ready output register. A sample offered while the
// register is full and the consumer is stalled is dropped and flagged.
module nmr_out_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_flush,
  input  logic              i_load_req,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_drop
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_drop;
  logic              w_load;

  // A full, stalled register cannot accept; an accepted-this-cycle
  // register can be refilled in the same cycle.
  assign w_drop = i_load_req & r_valid & ~i_out_ready;
  assign w_load = i_load_req & ~w_drop;

  // Hold, refill or empty the output register.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values, matching the hardware regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_drop      = w_drop;

endmodule

// File: rtl/nmr_echo_sample_gate.sv
// Gates the free-running ADC stream into samples_per_echo samples for each
// of echoes_per_scan acquisition windows and hands them to the FIFO.
// Optional build macro: NMR_ECHO_TAG_EN (prepends echo_idx[15:0] to each word).
module nmr_echo_sample_gate
  import nmr_acq_pkg::*;
#(
  parameter  int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter  int CNT_WIDTH = CNT_WIDTH_DEF,
  localparam int OUT_W     = out_width(ADC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] samples_per_echo,
  input  logic [CNT_WIDTH-1:0] echoes_per_scan,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 acq_win,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] echo_idx,
  output logic [CNT_WIDTH-1:0] sample_idx
);

  state_e               r_state;
  state_e               w_next_state;

  logic                 r_acq_win_d;
  logic [CNT_WIDTH-1:0] r_spe;
  logic [CNT_WIDTH-1:0] r_eps;
  logic [CNT_WIDTH-1:0] r_echo_idx;
  logic [CNT_WIDTH-1:0] r_sample_idx;
  logic                 r_done;
  logic                 r_overflow;

  logic                 w_win_rise;
  logic                 w_last_sample;
  logic                 w_last_echo;
  logic                 w_zero_param;
  logic                 w_out_valid;
  logic                 w_drop;
  logic [OUT_W-1:0]     w_stage_data;

  logic                 w_busy;
  logic                 w_arm_take;
  logic                 w_sample_take;
  logic                 w_finish_done;

  assign w_win_rise    = acq_win & ~r_acq_win_d;
  assign w_last_sample = (r_sample_idx == r_spe - CNT_WIDTH'(1));
  assign w_last_echo   = (r_echo_idx == r_eps - CNT_WIDTH'(1));
  assign w_zero_param  = (samples_per_echo == '0) || (echoes_per_scan == '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic; abort overrides every other event.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (arm) w_next_state = w_zero_param ? FINISH : WAIT_WIN;
        end
        WAIT_WIN: begin
          if (w_win_rise) w_next_state = CAPTURE;
        end
        CAPTURE: begin
          if (adc_valid && w_last_sample)
            w_next_state = w_last_echo ? FINISH : WAIT_WIN;
        end
        FINISH: begin
          if (!w_out_valid) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State-decoded strobes for the datapath and the busy flag.
  always_comb begin
    w_busy        = 1'b0;
    w_arm_take    = 1'b0;
    w_sample_take = 1'b0;
    w_finish_done = 1'b0;
    unique case (r_state)
      IDLE:     w_arm_take    = arm & ~abort;
      WAIT_WIN: w_busy        = 1'b1;
      CAPTURE: begin
        w_busy        = 1'b1;
        w_sample_take = adc_valid & ~abort;
      end
      FINISH: begin
        w_busy        = 1'b1;
        w_finish_done = ~w_out_valid & ~abort;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Registered copy of the window for rising-edge detection; it tracks in
  // every state so a window already high on entry to WAIT_WIN is no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_acq_win_d <= 1'b0;
    else          r_acq_win_d <= acq_win;
  end

  // Scan parameters are sampled only when a scan is armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spe <= '0;
      r_eps <= '0;
    end else if (w_arm_take) begin
      r_spe <= samples_per_echo;
      r_eps <= echoes_per_scan;
    end
  end

  // Echo/sample position; dropped samples still count so echo timing holds.
  // After the final sample echo_idx reads echoes_per_scan (echoes completed).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_echo_idx   <= '0;
      r_sample_idx <= '0;
    end else if (w_arm_take) begin
      r_echo_idx   <= '0;
      r_sample_idx <= '0;
    end else if (w_sample_take) begin
      if (w_last_sample) begin
        r_sample_idx <= '0;
        r_echo_idx   <= r_echo_idx + CNT_WIDTH'(1);
      end else begin
        r_sample_idx <= r_sample_idx + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky status flags, cleared only by a fresh arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_arm_take) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_finish_done) r_done     <= 1'b1;
      if (w_drop)        r_overflow <= 1'b1;
    end
  end

`ifdef NMR_ECHO_TAG_EN
  assign w_stage_data = {r_echo_idx[ECHO_TAG_W-1:0], adc_data};
`else
  assign w_stage_data = adc_data;
`endif

  nmr_out_stage #(
    .DATA_W (OUT_W)
  ) u_out_stage (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (abort),
    .i_load_req  (w_sample_take),
    .i_load_data (w_stage_data),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_valid (w_out_valid),
    .o_drop      (w_drop)
  );

  assign out_valid  = w_out_valid;
  assign busy       = w_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign echo_idx   = r_echo_idx;
  assign sample_idx = r_sample_idx;

endmodule

// File: tb/tb_nmr_echo_sample_gate.sv
// Scoreboard bench for nmr_echo_sample_gate. The expected stream is the first
// samples_per_echo ADC samples after each acquisition-window rising edge.
module tb_nmr_echo_sample_gate;

  localparam int ADC_W = 16;
  localparam int CNT_W = 32;
`ifdef NMR_ECHO_TAG_EN
  localparam int OUT_W = ADC_W + 16;
`else
  localparam int OUT_W = ADC_W;
`endif

  logic             clk;
  logic             reset_n;
  logic [CNT_W-1:0] samples_per_echo;
  logic [CNT_W-1:0] echoes_per_scan;
  logic             arm;
  logic             abort;
  logic             acq_win;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] echo_idx;
  logic [CNT_W-1:0] sample_idx;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [OUT_W-1:0] sb[$];

  nmr_echo_sample_gate dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .samples_per_echo (samples_per_echo),
    .echoes_per_scan  (echoes_per_scan),
    .arm              (arm),
    .abort            (abort),
    .acq_win          (acq_win),
    .adc_data         (adc_data),
    .adc_valid        (adc_valid),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .echo_idx         (echo_idx),
    .sample_idx       (sample_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected FIFO word for a sample captured during echo e.
  function automatic logic [OUT_W-1:0] mk(input int e, input logic [ADC_W-1:0] d);
    logic [15:0] tag;
    tag = 16'(e);
`ifdef NMR_ECHO_TAG_EN
    return {tag, d};
`else
    if (tag == 16'hffff) return d;  // tag unused in this build
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("out_unexpected", out_valid, 1'b0);
        else                check("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic pulse_arm(input int n, input int m);
    samples_per_echo = CNT_W'(n);
    echoes_per_scan  = CNT_W'(m);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  // One random scan with out_ready held high.
  task automatic run_scan(input int n, input int m);
    int base;
    int cnt;
    int fall_at;
    int guard;
    adc_valid = 1'b0;
    acq_win   = 1'b0;
    base      = n_out;
    pulse_arm(n, m);
    check("arm_idx", {echo_idx, sample_idx}, 64'd0);
    check("arm_busy", busy, (n == 0 || m == 0) ? 1'b1 : 1'b1);
    samples_per_echo = $urandom_range(0, 9);  // mid-scan change must not matter
    echoes_per_scan  = $urandom_range(0, 9);
    if (n > 0 && m > 0) begin
      for (int e = 0; e < m; e++) begin
        repeat ($urandom_range(1, 3)) begin
          acq_win   = 1'b0;
          adc_valid = 1'($urandom % 2);
          adc_data  = ADC_W'($urandom);
          tick();
        end
        acq_win   = 1'b1;   // rising-edge cycle: sample here is not captured
        adc_valid = 1'b1;
        adc_data  = ADC_W'($urandom);
        tick();
        cnt     = 0;
        guard   = 0;
        fall_at = $urandom_range(0, n);
        while (cnt < n) begin
          if (cnt >= fall_at) acq_win = 1'b0;
          adc_valid = ($urandom % 3 != 0) || (guard > 3 * n);
          adc_data  = ADC_W'($urandom);
          if (adc_valid) begin
            sb.push_back(mk(e, adc_data));
            cnt++;
          end
          guard++;
          tick();
        end
        repeat (2) begin
          adc_valid = 1'b1;
          adc_data  = ADC_W'($urandom);
          tick();
        end
        adc_valid = 1'b0;
      end
    end
    wait_done("scan");
    check("scan_count", n_out - base, n * m);
  endtask

  initial begin
    logic [ADC_W-1:0] d [8];
    int base;

    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; acq_win = 1'b0;
    adc_data = '0; adc_valid = 1'b0; out_ready = 1'b1;
    samples_per_echo = 32'd255; echoes_per_scan = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_echo_idx", echo_idx, 0);
    check("rst_sample_idx", sample_idx, 0);
    reset_n = 1'b1;
    tick();

    // Nominal: N=4, M=3, six samples offered per window.
    base = n_out;
    pulse_arm(4, 3);
    for (int e = 0; e < 3; e++) begin
      acq_win = 1'b0; tick();
      acq_win = 1'b1; adc_valid = 1'b0; tick();
      for (int s = 0; s < 6; s++) begin
        adc_valid = 1'b1;
        adc_data  = ADC_W'(16'h1000 * (e + 1) + s);
        if (s < 4) sb.push_back(mk(e, adc_data));
        tick();
      end
      adc_valid = 1'b0;
    end
    acq_win = 1'b0;
    wait_done("nominal");
    check("nominal_count", n_out - base, 12);
    check("nominal_overflow", overflow, 0);

    // Zero parameter: straight to done, no output.
    base = n_out;
    pulse_arm(0, 3);
    for (int k = 0; k < 3; k++) begin
      if (done) break;
      tick();
    end
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_count", n_out - base, 0);

    // Overflow: consumer stalled for the first two samples, N=8, M=1.
    base = n_out;
    for (int i = 0; i < 8; i++) d[i] = ADC_W'($urandom);
    pulse_arm(8, 1);
    acq_win = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) out_ready = 1'b1;
      adc_valid = 1'b1;
      adc_data  = d[i];
      if (i != 1) sb.push_back(mk(0, d[i]));
      tick();
      if (i == 1) begin
        check("ovf_flag", overflow, 1'b1);
        check("ovf_held_valid", out_valid, 1'b1);
        check("ovf_held_data", out_data[ADC_W-1:0], d[0]);
      end
    end
    adc_valid = 1'b0; acq_win = 1'b0;
    wait_done("ovf");
    check("ovf_count", n_out - base, 7);
    check("ovf_sticky", overflow, 1'b1);

    // Abort in CAPTURE at sample_idx=2.
    pulse_arm(6, 2);
    check("abort_arm_ovf_clear", overflow, 1'b0);
    acq_win = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      adc_valid = 1'b1;
      adc_data  = ADC_W'($urandom);
      sb.push_back(mk(0, adc_data));
      tick();
    end
    check("abort_pre_idx", sample_idx, 2);
    abort = 1'b1; adc_valid = 1'b1; adc_data = ADC_W'($urandom);
    tick();
    abort = 1'b0; adc_valid = 1'b0; acq_win = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_idx_hold", sample_idx, 2);
    tick();
    check("abort_sb_drained", sb.size(), 0);
    run_scan(3, 2);

    // Window already high at arm; a second arm while busy is ignored.
    base = n_out;
    acq_win = 1'b1; tick();
    pulse_arm(2, 1);
    repeat (4) begin
      adc_valid = 1'b1; adc_data = ADC_W'($urandom); tick();
    end
    adc_valid = 1'b0;
    check("prehigh_no_out", n_out - base, 0);
    pulse_arm(5, 1);
    check("rearm_busy", busy, 1'b1);
    acq_win = 1'b0; tick();
    acq_win = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1;
      adc_data  = ADC_W'($urandom);
      if (i < 2) sb.push_back(mk(0, adc_data));
      tick();
    end
    adc_valid = 1'b0; acq_win = 1'b0;
    wait_done("prehigh");
    check("prehigh_count", n_out - base, 2);

    // One sample per echo: the tag build sees tags 0, 1, 2.
    run_scan(1, 3);

    // Randomized scans.
    for (int t = 0; t < 10; t++) run_scan($urandom_range(0, 6), $urandom_range(0, 4));

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
